// File: rtl/mult_rr_arbiter_pkg.sv
// mult_rr_arbiter_pkg
//   Shared constants and helpers for the round-robin multiplier arbiter.
//   - DefNumReq / DefDw / DefPipeLat : default build configuration
//   - DefPw                          : default product width (2*DW)
//   - clog2()                        : index width for a requester count (minimum 1)
//   - stage_t                        : operand-stage bundle {valid, id, a, b} at default widths

package mult_rr_arbiter_pkg;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefDw      = 16;
    localparam int unsigned DefPw      = 2 * DefDw;
    localparam int unsigned DefPipeLat = 2;

    // Returns at least 1 so a 1-bit id field exists even for tiny counts.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    localparam int unsigned DefIdW = clog2(DefNumReq);

    typedef struct packed {
        logic              valid;
        logic [DefIdW-1:0] id;
        logic [DefDw-1:0]  a;
        logic [DefDw-1:0]  b;
    } stage_t;

endpackage

// File: rtl/mult_rr_arbiter_if.sv
// mult_rr_arbiter_if
//   Request/response bundle between the requesters, the consumer and the arbiter.
//   - req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   - req_a/req_b         : packed operands, requester i at [i*DW +: DW]
//   - rsp_valid/rsp_ready : result handshake
//   - rsp_id/rsp_prod     : owning requester index and 2*DW-bit product
//   Modports: master = requester/consumer side, slave = arbiter side.

interface mult_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned ID_W    = mult_rr_arbiter_pkg::clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [2*DW-1:0]       rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );

endinterface

// File: rtl/mult_rr_arbiter_pipe.sv
// mult_rr_arbiter_pipe
//   PIPE_LAT-deep enable-gated register chain around a DWxDW multiplier.
//   Stage 1 captures operands; the product is formed from stage 1 and carried
//   through the remaining stages together with its valid bit and requester id.
//   - i_clk, i_rst       : clock, synchronous active-high reset
//   - i_en               : advance; 0 holds every stage
//   - i_valid, i_id      : entry valid and owner id
//   - i_a, i_b           : operands
//   - o_valid, o_id      : last-stage valid and owner id
//   - o_prod             : 2*DW product
//   - o_busy             : OR of all stage valids

module mult_rr_arbiter_pipe #(
    parameter int unsigned DW       = 16,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned PIPE_LAT = 2,
    parameter bit          SIGNED   = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic [ID_W-1:0] i_id,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id,
    output logic [2*DW-1:0] o_prod,
    output logic            o_busy
);

    localparam int unsigned PW = 2 * DW;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
    } op_stage_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [PW-1:0]   prod;
    } res_stage_t;

    op_stage_t     r_op;
    logic [PW-1:0] w_a_ext;
    logic [PW-1:0] w_b_ext;
    logic [PW-1:0] w_prod;

    // Extending to PW first makes the low PW bits of the product exact for both modes.
    always_comb begin
        if (SIGNED) begin
            w_a_ext = {{DW{r_op.a[DW-1]}}, r_op.a};
            w_b_ext = {{DW{r_op.b[DW-1]}}, r_op.b};
        end else begin
            w_a_ext = {{DW{1'b0}}, r_op.a};
            w_b_ext = {{DW{1'b0}}, r_op.b};
        end
        w_prod = w_a_ext * w_b_ext;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op <= '0;
        end else if (i_en) begin
            r_op.valid <= i_valid;
            r_op.id    <= i_id;
            r_op.a     <= i_a;
            r_op.b     <= i_b;
        end
    end

    if (PIPE_LAT == 1) begin : g_lat1
        assign o_valid = r_op.valid;
        assign o_id    = r_op.id;
        assign o_prod  = w_prod;
        assign o_busy  = r_op.valid;
    end else begin : g_latn
        res_stage_t r_res [PIPE_LAT-1];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
                    r_res[i] <= '0;
                end
            end else if (i_en) begin
                r_res[0].valid <= r_op.valid;
                r_res[0].id    <= r_op.id;
                r_res[0].prod  <= w_prod;
                for (int i = 1; i < int'(PIPE_LAT) - 1; i++) begin
                    r_res[i] <= r_res[i-1];
                end
            end
        end

        always_comb begin
            o_busy = r_op.valid;
            for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
                o_busy = o_busy | r_res[i].valid;
            end
        end

        assign o_valid = r_res[PIPE_LAT-2].valid;
        assign o_id    = r_res[PIPE_LAT-2].id;
        assign o_prod  = r_res[PIPE_LAT-2].prod;
    end

endmodule

// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter
//   Shares one pipelined multiplier among NUM_REQ requesters. A round-robin
//   pointer picks at most one operand pair per cycle; results leave in grant
//   order tagged with the requester index.
//   - i_sys_clk : clock
//   - i_sys_rst : synchronous active-high reset
//   - bus       : request/response bundle (slave side)
//   - o_busy    : any pipeline stage holds a valid entry

module mult_rr_arbiter
    import mult_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned DW       = DefDw,
    parameter int unsigned PIPE_LAT = DefPipeLat,
    parameter bit          SIGNED   = 1'b1
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    mult_rr_arbiter_if.slave  bus,
    output logic              o_busy
);

    localparam int unsigned ID_W = clog2(NUM_REQ);

    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_next;
    logic               w_adv;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_any;
    logic [ID_W-1:0]    w_grant_id;
    logic [DW-1:0]      w_a;
    logic [DW-1:0]      w_b;
    logic               w_out_valid;
    logic [ID_W-1:0]    w_out_id;
    logic [2*DW-1:0]    w_out_prod;

    // Stall only while a finished result is waiting on the consumer.
    assign w_adv = !(w_out_valid && !bus.rsp_ready);

    // Scan from r_ptr upward with wrap; first valid requester wins.
    always_comb begin
        int unsigned idx;
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        idx         = 0;
        if (!i_sys_rst && w_adv) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(r_ptr) + k) % NUM_REQ;
                if (!w_grant_any && bus.req_valid[idx]) begin
                    w_grant_any  = 1'b1;
                    w_grant_id   = ID_W'(idx);
                    w_grant[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (w_grant_id == ID_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_ptr <= '0;
        end else if (w_grant_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign w_a = bus.req_a[w_grant_id*DW +: DW];
    assign w_b = bus.req_b[w_grant_id*DW +: DW];

    mult_rr_arbiter_pipe #(
        .DW       (DW),
        .ID_W     (ID_W),
        .PIPE_LAT (PIPE_LAT),
        .SIGNED   (SIGNED)
    ) u_pipe (
        .i_clk   (i_sys_clk),
        .i_rst   (i_sys_rst),
        .i_en    (w_adv),
        .i_valid (w_grant_any),
        .i_id    (w_grant_id),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_valid (w_out_valid),
        .o_id    (w_out_id),
        .o_prod  (w_out_prod),
        .o_busy  (o_busy)
    );

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = w_out_valid;
    assign bus.rsp_id    = w_out_id;
    assign bus.rsp_prod  = w_out_prod;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter
//   Directed scenarios with literal expectations, then randomized traffic.
//   A queue-based model tracks grants and in-flight results and is compared
//   against the signed DUT every cycle; a second unsigned build gets literal checks.

module tb_mult_rr_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic busy_u;

    always #5 clk = ~clk;

    mult_rr_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();
    mult_rr_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus_u ();

    mult_rr_arbiter #(
        .NUM_REQ  (NR),
        .DW       (DW),
        .PIPE_LAT (LAT),
        .SIGNED   (1'b1)
    ) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus),
        .o_busy    (busy)
    );

    mult_rr_arbiter #(
        .NUM_REQ  (NR),
        .DW       (DW),
        .PIPE_LAT (1),
        .SIGNED   (1'b0)
    ) dut_u (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .bus       (bus_u),
        .o_busy    (busy_u)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        logic [31:0] prod;
        int          ticks;   // advancing cycles since acceptance
    } item_t;

    item_t m_q[$];
    int    m_ptr = 0;

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'(shortint'(a)) * int'(shortint'(b));
        return p;
    endfunction

    always @(negedge clk) begin : model
        logic       exp_rv;
        logic       adv;
        logic [3:0] exp_rdy;
        int         gi;
        item_t      it;
        exp_rv  = (m_q.size() > 0) && (m_q[0].ticks == LAT);
        adv     = !(exp_rv && !bus.rsp_ready);
        exp_rdy = '0;
        gi      = -1;
        if (!rst && adv) begin
            for (int k = 0; k < NR; k++) begin
                if (gi < 0 && bus.req_valid[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
            end
        end
        if (gi >= 0) exp_rdy[gi] = 1'b1;
        chk("model_req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("model_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        chk("model_busy", 64'(busy), 64'(m_q.size() > 0));
        if (exp_rv) begin
            chk("model_rsp_id", 64'(bus.rsp_id), 64'(m_q[0].id));
            chk("model_rsp_prod", 64'(bus.rsp_prod), 64'(m_q[0].prod));
        end
        if (rst) begin
            m_q.delete();
            m_ptr = 0;
        end else if (adv) begin
            if (exp_rv) void'(m_q.pop_front());
            foreach (m_q[i]) m_q[i].ticks++;
            if (gi >= 0) begin
                it.id    = gi;
                it.prod  = ref_prod(bus.req_a[gi*DW +: DW], bus.req_b[gi*DW +: DW]);
                it.ticks = 1;
                m_q.push_back(it);
                m_ptr = (gi + 1) % NR;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [3:0] exp_g2 [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] exp_g5 [3] = '{4'b1000, 4'b0010, 4'b1000};
    int         ids[$];

    initial begin
        bus.req_valid   = 4'hF;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.rsp_ready   = 1'b1;
        bus_u.req_valid = '0;
        bus_u.req_a     = '0;
        bus_u.req_b     = '0;
        bus_u.rsp_ready = 1'b1;

        // Reset state, with every requester asking
        step(); step(); mid();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_prod", 64'(bus.rsp_prod), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        step(); rst = 1'b0; bus.req_valid = '0;

        // Single request 3 * -5
        step(); bus.req_valid = 4'b0001; bus.req_a[0 +: 16] = 16'd3; bus.req_b[0 +: 16] = 16'hFFFB;
        mid(); chk("t1_grant", 64'(bus.req_ready), 64'b0001);
        step(); bus.req_valid = '0;
        mid(); chk("t1_early", 64'(bus.rsp_valid), 64'd0);
        step(); mid();
        chk("t1_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_prod", 64'(bus.rsp_prod), 64'hFFFF_FFF1);
        chk("t1_id", 64'(bus.rsp_id), 64'd0);
        step(); mid(); chk("t1_one_cycle", 64'(bus.rsp_valid), 64'd0);

        // All requesters continuously valid, from ptr=0
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        bus.req_a = {16'd4, 16'd3, 16'd2, 16'd1};
        bus.req_b = {16'd5, 16'd4, 16'd3, 16'd2};
        for (int c = 0; c < 9; c++) begin
            step(); bus.req_valid = (c < 6) ? 4'hF : 4'h0;
            mid();
            if (c < 6) chk("t2_grant", 64'(bus.req_ready), 64'(exp_g2[c]));
            if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
        end
        chk("t2_rsp_count", 64'(ids.size()), 64'd6);
        for (int i = 0; i < ids.size() && i < 6; i++) chk("t2_rsp_id", 64'(ids[i]), 64'(i % 4));

        // Pointer skip: ptr=2, only 1 and 3 valid
        bus.req_a = {16'd7, 16'd0, 16'd9, 16'd0};
        for (int c = 0; c < 3; c++) begin
            step(); bus.req_valid = 4'b1010;
            mid(); chk("t5_grant", 64'(bus.req_ready), 64'(exp_g5[c]));
        end
        step(); bus.req_valid = '0;
        step(); step();

        // Backpressure with two results in flight (ptr=0)
        step(); bus.req_valid = 4'b0001; bus.req_a[0 +: 16] = 16'd100; bus.req_b[0 +: 16] = 16'd7;
        mid(); chk("t3_grant0", 64'(bus.req_ready), 64'b0001);
        step(); bus.req_valid = 4'b0010; bus.req_a[16 +: 16] = 16'hFFF7; bus.req_b[16 +: 16] = 16'd11;
        mid(); chk("t3_grant1", 64'(bus.req_ready), 64'b0010);
        step(); bus.req_valid = 4'b0100; bus.req_a[32 +: 16] = 16'd5; bus.req_b[32 +: 16] = 16'd6;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            mid();
            chk("t3_hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("t3_hold_prod", 64'(bus.rsp_prod), 64'd700);
            chk("t3_hold_id", 64'(bus.rsp_id), 64'd0);
            chk("t3_stall_ready", 64'(bus.req_ready), 64'd0);
        end
        step(); bus.rsp_ready = 1'b1; bus.req_valid = 4'b0101;
        mid();
        chk("t3_rel_prod", 64'(bus.rsp_prod), 64'd700);
        chk("t3_ptr_frozen", 64'(bus.req_ready), 64'b0100);
        step(); bus.req_valid = '0;
        mid();
        chk("t3_second_prod", 64'(bus.rsp_prod), 64'hFFFF_FF9D);
        chk("t3_second_id", 64'(bus.rsp_id), 64'd1);
        step(); mid();
        chk("t3_third_prod", 64'(bus.rsp_prod), 64'd30);
        chk("t3_third_id", 64'(bus.rsp_id), 64'd2);
        step(); mid(); chk("t3_drained", 64'(bus.rsp_valid), 64'd0);

        // Operand corners (ptr=3), plus the unsigned build
        step(); bus.req_valid = 4'b1000; bus.req_a[48 +: 16] = 16'h8000; bus.req_b[48 +: 16] = 16'h8000;
        bus_u.req_valid = 4'b0100; bus_u.req_a[32 +: 16] = 16'hFFFF; bus_u.req_b[32 +: 16] = 16'hFFFF;
        mid();
        chk("t4_grant3", 64'(bus.req_ready), 64'b1000);
        chk("t4u_grant", 64'(bus_u.req_ready), 64'b0100);
        step(); bus.req_valid = 4'b0001; bus.req_a[0 +: 16] = 16'h7FFF; bus.req_b[0 +: 16] = 16'h8000;
        bus_u.req_valid = '0;
        mid();
        chk("t4u_valid", 64'(bus_u.rsp_valid), 64'd1);
        chk("t4u_prod", 64'(bus_u.rsp_prod), 64'hFFFE_0001);
        chk("t4u_id", 64'(bus_u.rsp_id), 64'd2);
        step(); bus.req_valid = '0;
        mid(); chk("t4_min_min", 64'(bus.rsp_prod), 64'h4000_0000);
        step(); mid(); chk("t4_max_min", 64'(bus.rsp_prod), 64'hC000_8000);

        // Reset with two results in flight (ptr=1)
        step(); bus.req_valid = 4'b0100;
        step(); bus.req_valid = 4'b1000;
        step(); bus.req_valid = '0; rst = 1'b1; bus.rsp_ready = 1'b0;
        step(); rst = 1'b0; bus.rsp_ready = 1'b1;
        mid();
        chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        for (int c = 0; c < 4; c++) begin
            step(); mid(); chk("t6_no_stale", 64'(bus.rsp_valid), 64'd0);
        end
        step(); bus.req_valid = 4'b1010;
        mid(); chk("t6_lowest", 64'(bus.req_ready), 64'b0010);
        step(); bus.req_valid = '0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            rst           = ($urandom_range(0, 299) == 0);
            bus.req_valid = (c % 2 == 0) ? 4'($urandom()) : 4'($urandom() & $urandom());
            bus.req_a     = {$urandom(), $urandom()};
            bus.req_b     = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) bus.req_a[16*$urandom_range(0, 3) +: 16] = 16'h8000;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        step(); rst = 1'b0; bus.req_valid = '0; bus.rsp_ready = 1'b1;
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
Shares one pipelined 16x16 signed multiplier among NUM_REQ independent requesters.
Round-robin arbitration grants at most one operand pair per cycle. Each result returns with the requester index.
Sits between the requesting datapath blocks and the Booth-4/Wallace multiplier core. It is the sequencing and sharing layer for that core.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- DW, 16: operand width; product width is 2*DW.
- PIPE_LAT, 2: cycles from request handshake to rsp_valid; must be ≥1.
- SIGNED, 1: 1 = two's-complement multiply; 0 = unsigned.

Ports:
- sys_clk, in, 1: single clock; all state updates on the rising edge.
- sys_rst, in, 1: synchronous, active-high reset.
- req_valid, in, NUM_REQ: per-requester request valid.
- req_ready, out, NUM_REQ: per-requester grant; one-hot or zero.
- req_a, in, NUM_REQ*DW: packed operand A; requester i occupies bits [i*DW +: DW].
- req_b, in, NUM_REQ*DW: packed operand B, same packing as req_a.
- rsp_valid, out, 1: result valid.
- rsp_ready, in, 1: consumer accepts result.
- rsp_id, out, clog2(NUM_REQ): index of the requester that owns the result.
- rsp_prod, out, 2*DW: product.
- busy, out, 1: OR of all pipeline-stage valids.

Interface decision: one clock, sys_clk. Reset sys_rst is synchronous and active-high.

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0.
  - All pipeline valids cleared; round-robin pointer ptr=0.
  - req_ready=0 while sys_rst=1.
- Advance condition: adv = !(rsp_valid && !rsp_ready).
  - adv=0: every pipeline stage holds its contents, and req_ready = 0.
- Arbitration (combinational, when adv=1):
  - Scan indices ptr, ptr+1, …, wrapping mod NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0.
  - req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
- Handshake: a request is taken when req_valid[i] && req_ready[i].
  - On a handshake: ptr <= (i+1) mod NUM_REQ, and {valid=1, id=i, a, b} enter stage 1.
  - No handshake: ptr unchanged; a bubble (valid=0) enters stage 1 if adv=1.
- Requester obligation: hold req_valid and operands stable until handshake. The block does not check this.
- Latency: handshake in cycle t gives rsp_valid=1 in cycle t+PIPE_LAT, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one result per cycle while rsp_ready=1.
- Ordering: results leave in grant order; no reordering.
- Arithmetic:
  - SIGNED=1: full-precision signed product, sign-extended to 2*DW.
  - SIGNED=0: zero-extended operands.
  - No truncation or overflow is possible.
- Output hold: while rsp_valid && !rsp_ready, rsp_prod and rsp_id stay stable.
- Idle: with no requests, ptr is frozen and busy=0 once the pipeline drains.
- Reset mid-operation: all in-flight results are discarded with no response emitted. ptr returns to 0.
- A requester deasserting req_valid before its grant is legal; nothing is recorded for it.

Decomposition:
- Package mult_pkg holds:
  - DW and product-width constants.
  - A clog2 function for ID_W.
  - The pipeline-stage struct/typedef {valid, id, a, b}.
- Sub-module mult_pipe(DW, PIPE_LAT, SIGNED):
  - Inputs: en=adv, in_valid, in_id, a, b.
  - Outputs: out_valid, out_id, prod.
  - Internally a PIPE_LAT-deep register chain around the multiplier core; the stage contents are enable-gated.
- The arbiter top holds the pointer, the grant logic, and the adv/stall logic.

Test Plan:
1. Single request: requester 0 sends a=3, b=-5 (0xFFFB) with rsp_ready=1 → after 2 cycles, rsp_valid=1, rsp_prod=0xFFFFFFF1, rsp_id=0, valid for exactly one cycle.
2. All four requesters hold req_valid=1 continuously → grants in order 0,1,2,3,0,1; one rsp_valid per cycle; rsp_id sequence matches grant order.
3. Backpressure: with two results in flight, rsp_ready=0 for 3 cycles → rsp_prod/rsp_id held, req_ready=0, ptr frozen. After release, both results arrive in order with none lost or duplicated.
4. Operand corners:
   - -32768 × -32768 → 0x40000000.
   - 32767 × -32768 → 0xC0008000.
   - SIGNED=0 build: 0xFFFF × 0xFFFF → 0xFFFE0001.
5. Pointer skip: ptr=2, only requesters 1 and 3 valid → grant 3 first, then 1; afterwards ptr=2.
6. Reset mid-operation: pulse sys_rst for one cycle with 2 results in flight → next cycle rsp_valid=0 and busy=0; no stale result appears later; the next grant goes to the lowest valid index.
